prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader upstream of the 5-stage MIPS core. It receives a length-prefixed program image over a UART RX line and writes it word by word into the core's instruction memory write port. Once the image is complete it releases the core's active-high reset. It sits between the board's serial pin and the instruction memory and core reset in the top-level.

## Interface
Parameters:
- CLK_HZ, 100000000, system clock frequency.
- BAUD, 115200, UART bit rate; DIV = CLK_HZ/BAUD, truncated, must be ≥ 4.
- ADDR_WIDTH, 12, instruction memory word-address width; capacity is 2**ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rxd  in  1  UART receive line; asynchronous, idles high.
- imem_addr  out  ADDR_WIDTH  word address for the instruction memory write.
- imem_wdata  out  32  word to write.
- imem_we  out  1  one-cycle write strobe.
- cpu_rst  out  1  active-high reset to the core; held at 1 until loading is done.
- busy  out  1  1 while in LEN or DATA.
- err  out  1  sticky: length overflow or framing error seen since reset.
- word_cnt  out  ADDR_WIDTH+1  words written so far.

## Operation
- Reset values (rst=0): imem_addr=0, imem_wdata=0, imem_we=0, cpu_rst=1, busy=1, err=0, word_cnt=0, state=LEN, byte index=0.
- UART receiver, 8N1, LSB first:
  - rxd passes through a 2-FF synchronizer.
  - A falling edge while idle starts a frame. The line is sampled DIV/2 cycles later; if it is high, the start is treated as a glitch and the receiver returns to idle.
  - Each data bit is then sampled every DIV cycles, followed by the stop bit.
  - Stop bit = 0: framing error. The byte is discarded and err is set.
  - Stop bit = 1: byte_valid pulses for one cycle with byte_data.
- Word assembly: bytes arrive little-endian (first byte → bits 7:0). A 2-bit byte index wraps 3→0. A word is complete on the 4th byte.
- FSM states:
  - LEN: the first complete word is N, the program length in words.
    - N=0 → RUN.
    - N > 2**ADDR_WIDTH → ERR, err=1.
    - Otherwise → DATA; the stored remaining count is N.
  - DATA: on each complete word, pulse imem_we with imem_wdata=word and imem_addr=word_cnt[ADDR_WIDTH-1:0]. Increment word_cnt and decrement the remaining count. When the remaining count reaches 0 after a write → RUN.
  - RUN: cpu_rst=0, busy=0. Further bytes are ignored. Leaving RUN requires rst.
  - ERR: cpu_rst stays 1, busy=0, bytes are ignored. Leaving ERR requires rst.
- Address wrap cannot occur: N is bounded by capacity, so the highest address written is N-1.
- A framing error inside a word does not advance the byte index; the corrupted byte is simply missing. The image is then misaligned, and the host must reset and resend.
- rst asserted mid-frame or mid-image aborts immediately to reset values. Instruction memory contents already written are not cleared.

## Timing
- byte_valid occurs 1 cycle after the stop-bit sample. Total latency from the rxd start edge is about 2 sync cycles + DIV/2 + 9·DIV cycles.
- imem_we is registered and asserted in the cycle after byte_valid for the 4th byte. It is high for exactly 1 cycle. Address and data are stable during that cycle.
- cpu_rst falls in the cycle after the last imem_we, so the last write commits with the core still in reset. For N=0, cpu_rst falls the cycle after the length word completes.
- Maximum throughput is one byte per 10·DIV cycles, so strobes are spaced at least 40·DIV cycles apart. No backpressure exists, and none is needed.

## Structure
- Shared package/header holds the FSM state encoding (LEN=0, DATA=1, RUN=2, ERR=3) and the 8N1 frame constants (data bits 8, stop bits 1).
- One sub-module: uart_rx. Parameter DIV; ports clk, rst, rxd, byte_data[8], byte_valid, frame_err.
- prog_loader contains the word assembly, counters and FSM.

## Test plan
All scenarios use CLK_HZ=1600, BAUD=100 (DIV=16) and ADDR_WIDTH=4.
- Length word 2, then bytes 78 56 34 12 EF BE AD DE:
  - imem_we at addr 0 with 0x12345678, then at addr 1 with 0xDEADBEEF.
  - cpu_rst falls 1 cycle after the second strobe; word_cnt=2, err=0.
- Length word 0 → no imem_we; cpu_rst=0 one cycle after the 4th length byte; busy=0.
- Length word 17 (capacity is 16) → state ERR, err=1, cpu_rst stays 1, no imem_we even if 68 more bytes are sent.
- Byte 0xAA sent with stop bit 0 during DATA → err=1, byte index unchanged, no strobe from that byte.
- 3-cycle low glitch on idle rxd → no byte_valid, no state change.
- rst pulsed low in the middle of the second data word → all outputs at reset values immediately. Resending the full image then completes normally.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   - state_t    : loader FSM encoding (LEN=0, DATA=1, RUN=2, ERR=3)
//   - rx_state_t : UART receiver FSM encoding
//   - 8N1 frame constants
package prog_loader_pkg;

    typedef enum logic [1:0] {
        ST_LEN  = 2'd0,
        ST_DATA = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int FRAME_DATA_BITS = 8;
    localparam int FRAME_STOP_BITS = 1;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver, LSB first.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   rxd        : asynchronous serial input, idles high
//   byte_data  : received byte, valid while byte_valid is high
//   byte_valid : one-cycle pulse, the cycle after a good stop-bit sample
//   frame_err  : one-cycle pulse, the cycle after a low stop-bit sample
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW   = $clog2(DIV);
    localparam int HALF = DIV / 2;

    logic            sync1_reg, sync2_reg, prev_reg;
    rx_state_t       state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      bit_reg, bit_next;
    logic [7:0]      shift_reg, shift_next;
    logic [7:0]      data_reg, data_next;
    logic            valid_reg, valid_next;
    logic            ferr_reg, ferr_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
            state_reg <= RX_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            sync1_reg <= rxd;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                // Only a high-to-low transition starts a frame, so a line
                // held low after a bad frame does not retrigger.
                if (prev_reg && !sync2_reg) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                end
            end
            RX_START: begin
                if (cnt_reg == CW'(HALF - 1)) begin
                    cnt_next = '0;
                    bit_next = '0;
                    // Line already high again at mid-bit: treat as glitch.
                    state_next = sync2_reg ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_reg == CW'(DIV - 1)) begin
                    cnt_next   = '0;
                    shift_next = {sync2_reg, shift_reg[7:1]};
                    if (bit_reg == 3'(FRAME_DATA_BITS - 1)) begin
                        state_next = RX_STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_reg == CW'(DIV - 1)) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                    if (sync2_reg) begin
                        valid_next = 1'b1;
                        data_next  = shift_reg;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign byte_data  = data_reg;
    assign byte_valid = valid_reg;
    assign frame_err  = ferr_reg;

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length-prefixed, little-endian word
// image over UART and writes it into instruction memory, then releases the
// core's reset.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   rxd        : UART receive line
//   imem_addr  : instruction memory word address
//   imem_wdata : instruction word to write
//   imem_we    : one-cycle write strobe
//   cpu_rst    : active-high core reset, released after the image is loaded
//   busy       : high in LEN or DATA
//   err        : sticky length-overflow / framing-error flag
//   word_cnt   : number of words written
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  imem_we,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   word_cnt
);

    localparam int          DIV      = CLK_HZ / BAUD;
    localparam logic [31:0] CAPACITY = 32'(2 ** ADDR_WIDTH);

    logic [7:0]             byte_data;
    logic                   byte_valid;
    logic                   frame_err;

    state_t                 state_reg, state_next;
    logic [1:0]             bidx_reg;
    logic [ADDR_WIDTH:0]    rem_reg;
    logic [ADDR_WIDTH:0]    word_cnt_reg;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [31:0]            wdata_reg;
    logic                   we_reg;
    logic                   cpu_rst_reg;
    logic                   err_reg;

    logic                   loading;
    logic                   byte_accept;
    logic                   word_done;
    logic [31:0]            full_word;
    logic                   len_zero;
    logic                   len_over;

    uart_rx #(
        .DIV(DIV)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    assign loading     = (state_reg == ST_LEN) || (state_reg == ST_DATA);
    assign byte_accept = byte_valid && loading;
    assign word_done   = byte_accept && (bidx_reg == 2'd3);

    // Byte lanes 0..2 hold the partial word; lane 3 is taken directly from
    // the incoming byte so the word is usable in the byte_valid cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    lane_reg <= '0;
                end else if (byte_accept && bidx_reg == 2'(gi)) begin
                    lane_reg <= byte_data;
                end
            end
        end
    endgenerate

    assign full_word = {byte_data, g_lane[2].lane_reg, g_lane[1].lane_reg, g_lane[0].lane_reg};
    assign len_zero  = (full_word == 32'd0);
    assign len_over  = (full_word > CAPACITY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_LEN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LEN: begin
                if (word_done) begin
                    if (len_zero) begin
                        state_next = ST_RUN;
                    end else if (len_over) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_done && rem_reg == (ADDR_WIDTH + 1)'(1)) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = state_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bidx_reg     <= '0;
            rem_reg      <= '0;
            word_cnt_reg <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            we_reg       <= 1'b0;
            cpu_rst_reg  <= 1'b1;
            err_reg      <= 1'b0;
        end else begin
            we_reg <= 1'b0;
            // A byte lost to a framing error never reaches byte_accept, so
            // the index only moves on good bytes.
            if (byte_accept) begin
                bidx_reg <= bidx_reg + 2'd1;
            end
            if (state_reg == ST_LEN && word_done) begin
                rem_reg <= full_word[ADDR_WIDTH:0];
            end
            if (state_reg == ST_DATA && word_done) begin
                we_reg       <= 1'b1;
                addr_reg     <= word_cnt_reg[ADDR_WIDTH-1:0];
                wdata_reg    <= full_word;
                word_cnt_reg <= word_cnt_reg + (ADDR_WIDTH + 1)'(1);
                rem_reg      <= rem_reg - (ADDR_WIDTH + 1)'(1);
            end
            if (frame_err || (state_reg == ST_LEN && word_done && len_over)) begin
                err_reg <= 1'b1;
            end
            // Release one cycle after entering RUN so the final write lands
            // while the core is still held; an empty image releases directly.
            cpu_rst_reg <= !((state_reg == ST_RUN) ||
                             (state_reg == ST_LEN && word_done && len_zero));
        end
    end

    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign imem_we    = we_reg;
    assign cpu_rst    = cpu_rst_reg;
    assign busy       = loading;
    assign err        = err_reg;
    assign word_cnt   = word_cnt_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader (DIV=16, ADDR_WIDTH=4).
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd = 1'b1;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_we;
    logic        cpu_rst;
    logic        busy;
    logic        err;
    logic [4:0]  word_cnt;

    int errors = 0;
    int checks = 0;

    prog_loader #(
        .CLK_HZ    (1600),
        .BAUD      (100),
        .ADDR_WIDTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .imem_we   (imem_we),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .err       (err),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: logs strobes, byte_valid timing and cpu_rst falling edge.
    logic [3:0]  st_addr[$];
    logic [31:0] st_data[$];
    int          st_cyc[$];
    int          cyc = 0;
    int          bv_count = 0;
    int          bv_cyc = -1;
    int          fall_cyc = -1;
    logic        cpu_rst_prev = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (dut.byte_valid) begin
            bv_count++;
            bv_cyc = cyc;
        end
        if (imem_we) begin
            st_addr.push_back(imem_addr);
            st_data.push_back(imem_wdata);
            st_cyc.push_back(cyc);
            $display("strobe: cycle=%0d addr=%0d data=%h", cyc, imem_addr, imem_wdata);
        end
        if (cpu_rst_prev && !cpu_rst) fall_cyc = cyc;
        cpu_rst_prev = cpu_rst;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(negedge clk);
        end
        rxd = stop;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (imem_addr !== 4'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", imem_addr); end
        checks++; if (imem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", imem_wdata); end
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", imem_we); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (word_cnt !== 5'd0) begin errors++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_two_word_image(input string tag, input int base);
        checks++; if (st_addr.size() - base !== 2) begin errors++; $display("FAIL %s_strobes: got %0d expected 2", tag, st_addr.size() - base); end
        if (st_addr.size() - base >= 2) begin
            checks++; if (st_addr[base] !== 4'd0) begin errors++; $display("FAIL %s_addr0: got %0d expected 0", tag, st_addr[base]); end
            checks++; if (st_data[base] !== 32'h12345678) begin errors++; $display("FAIL %s_data0: got %h expected 12345678", tag, st_data[base]); end
            checks++; if (st_addr[base+1] !== 4'd1) begin errors++; $display("FAIL %s_addr1: got %0d expected 1", tag, st_addr[base+1]); end
            checks++; if (st_data[base+1] !== 32'hDEADBEEF) begin errors++; $display("FAIL %s_data1: got %h expected deadbeef", tag, st_data[base+1]); end
            checks++; if (fall_cyc !== st_cyc[base+1] + 1) begin errors++; $display("FAIL %s_cpu_rst_fall: got cycle %0d expected %0d", tag, fall_cyc, st_cyc[base+1] + 1); end
        end
        checks++; if (word_cnt !== 5'd2) begin errors++; $display("FAIL %s_word_cnt: got %0d expected 2", tag, word_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s_err: got %b expected 0", tag, err); end
        checks++; if (cpu_rst !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_run: got cpu_rst=%b busy=%b expected 0 0", tag, cpu_rst, busy); end
    endtask

    task automatic test_load_two();
        int base;
        do_reset();
        base = st_addr.size();
        send_word(32'd2);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        check_two_word_image("load2", base);
    endtask

    task automatic test_len_zero();
        int base;
        do_reset();
        base = st_addr.size();
        send_word(32'd0);
        checks++; if (st_addr.size() !== base) begin errors++; $display("FAIL len0_strobes: got %0d expected 0", st_addr.size() - base); end
        checks++; if (fall_cyc !== bv_cyc + 1) begin errors++; $display("FAIL len0_cpu_rst_fall: got cycle %0d expected %0d", fall_cyc, bv_cyc + 1); end
        checks++; if (cpu_rst !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL len0_run: got cpu_rst=%b busy=%b expected 0 0", cpu_rst, busy); end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        base = st_addr.size();
        send_word(32'd17);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", err); end
        checks++; if (cpu_rst !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ovf_state: got cpu_rst=%b busy=%b expected 1 0", cpu_rst, busy); end
        for (int i = 0; i < 68; i++) send_byte(8'(i * 37 + 5), 1'b1);
        checks++; if (st_addr.size() !== base) begin errors++; $display("FAIL ovf_strobes: got %0d expected 0", st_addr.size() - base); end
        checks++; if (cpu_rst !== 1'b1 || word_cnt !== 5'd0) begin errors++; $display("FAIL ovf_hold: got cpu_rst=%b word_cnt=%0d expected 1 0", cpu_rst, word_cnt); end
    endtask

    task automatic test_frame_err();
        int base;
        do_reset();
        base = st_addr.size();
        send_word(32'd1);
        send_byte(8'h11, 1'b1);
        send_byte(8'hAA, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ferr_err: got %b expected 1", err); end
        checks++; if (st_addr.size() !== base) begin errors++; $display("FAIL ferr_no_strobe: got %0d expected 0", st_addr.size() - base); end
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        checks++; if (st_addr.size() - base !== 1) begin errors++; $display("FAIL ferr_strobes: got %0d expected 1", st_addr.size() - base); end
        if (st_addr.size() - base >= 1) begin
            checks++; if (st_data[base] !== 32'h44332211) begin errors++; $display("FAIL ferr_data: got %h expected 44332211", st_data[base]); end
        end
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL ferr_cpu_rst: got %b expected 0", cpu_rst); end
    endtask

    task automatic test_glitch();
        int bv0;
        do_reset();
        bv0 = bv_count;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (bv_count !== bv0) begin errors++; $display("FAIL glitch_byte_valid: got %0d expected 0", bv_count - bv0); end
        checks++; if (busy !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b1) begin errors++; $display("FAIL glitch_state: got busy=%b err=%b cpu_rst=%b expected 1 0 1", busy, err, cpu_rst); end
        // Receiver must still accept a real frame afterwards.
        send_byte(8'h5A, 1'b1);
        checks++; if (bv_count !== bv0 + 1) begin errors++; $display("FAIL glitch_recover: got %0d bytes expected 1", bv_count - bv0); end
    endtask

    task automatic test_mid_reset();
        int base;
        do_reset();
        send_word(32'd2);
        send_word(32'h12345678);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        rxd = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (cpu_rst !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL midrst_flags: got cpu_rst=%b busy=%b err=%b expected 1 1 0", cpu_rst, busy, err); end
        checks++; if (word_cnt !== 5'd0 || imem_we !== 1'b0) begin errors++; $display("FAIL midrst_cnt: got word_cnt=%0d we=%b expected 0 0", word_cnt, imem_we); end
        checks++; if (imem_addr !== 4'd0 || imem_wdata !== 32'd0) begin errors++; $display("FAIL midrst_bus: got addr=%0d wdata=%h expected 0 0", imem_addr, imem_wdata); end
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        base = st_addr.size();
        send_word(32'd2);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        check_two_word_image("resend", base);
    endtask

    initial begin
        test_reset();
        test_load_two();
        test_len_zero();
        test_overflow();
        test_frame_err();
        test_glitch();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
